// File: rtl/el2_ifu_ic_dbg_pkg.sv
// ---------------------------------------------------------------------------
// el2_ifu_ic_dbg_pkg
//   Shared types and constants for the I-cache debug-port initiator
//   (el2_ifu_ic_dbg_ctl) and its counter sub-block (el2_ifu_ic_dbg_cnt).
//   No ports; contents:
//     IDX_W, DATA_W, TAG_W  : debug index, data word (incl. ECC), tag word widths
//     CNT_W                 : width of the shared latency/timeout down-counter
//     dbg_state_t           : controller FSM states
//     dbg_op_t              : latched operation kind
// ---------------------------------------------------------------------------
package el2_ifu_ic_dbg_pkg;

    localparam int IDX_W  = 9;
    localparam int DATA_W = 71;
    localparam int TAG_W  = 26;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        RDW   = 2'd3
    } dbg_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } dbg_op_t;

    // Tag reads come back right-aligned and zero-extended to the data word width.
    function automatic logic [DATA_W-1:0] sel_rd_data(
        input logic              tag_array,
        input logic [DATA_W-1:0] data_word,
        input logic [TAG_W-1:0]  tag_word
    );
        logic [DATA_W-1:0] word;
        word = data_word;
        if (tag_array) begin
            word = {{(DATA_W-TAG_W){1'b0}}, tag_word};
        end
        return word;
    endfunction

endpackage

// File: rtl/el2_ifu_ic_dbg_cnt.sv
// ---------------------------------------------------------------------------
// el2_ifu_ic_dbg_cnt
//   Loadable down-counter shared by the read-latency wait and the optional
//   grant-wait timeout. Load wins over decrement; the count saturates at zero.
//   Ports:
//     clock     in   core clock
//     io_rst_l  in   synchronous active-low reset (count -> 0)
//     load      in   load load_val this cycle
//     load_val  in   CNT_W value to load
//     dec       in   decrement by one (ignored at zero)
//     zero      out  count is zero
// ---------------------------------------------------------------------------
module el2_ifu_ic_dbg_cnt
    import el2_ifu_ic_dbg_pkg::*;
(
    input  logic             clock,
    input  logic             io_rst_l,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (!io_rst_l) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/el2_ifu_ic_dbg_ctl.sv
// ---------------------------------------------------------------------------
// el2_ifu_ic_dbg_ctl
//   Initiator side of the I-cache debug port. Takes one diagnostic read or
//   write request from the TLU, waits until the fetch path releases the
//   arrays (io_ic_busy low), issues a single-cycle access to ic_mem, and
//   returns a one-cycle rd_data_valid / wr_done pulse to the TLU.
//
//   Build option: EL2_IC_DBG_TIMEOUT_EN
//     defined   : grant wait is limited to TMO_CYC cycles; on expiry the
//                 request is abandoned, err pulses and a read also returns
//                 rd_data_valid with zero data.
//     undefined : grant wait is unbounded.
//
//   Parameters: RD_LAT (ic_mem read latency, >=1), TMO_CYC (1..255).
//   Ports:
//     clock, io_rst_l                 clock and synchronous active-low reset
//     io_diag_rd_valid/wr_valid       TLU request pulses
//     io_diag_addr/way/tag_array      request fields
//     io_diag_wr_data                 write data
//     io_ic_busy                      fetch path owns the arrays
//     io_ic_debug_*  (out)            access strobes and fields to ic_mem,
//                                     zero outside the issue cycle
//     io_ic_debug_rd_data (in)        data-array read word from ic_mem
//     io_ictag_debug_rd_data (in)     tag-array read word from ic_mem
//     io_diag_rd_data                 read response, held until next read
//     io_diag_rd_data_valid           one-cycle read completion pulse
//     io_diag_wr_done                 one-cycle write completion pulse
//     io_diag_busy                    controller not idle
//     io_diag_err                     dropped / conflicting / timed-out request
// ---------------------------------------------------------------------------
module el2_ifu_ic_dbg_ctl
    import el2_ifu_ic_dbg_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int TMO_CYC = 255
) (
    input  logic              clock,
    input  logic              io_rst_l,
    input  logic              io_diag_rd_valid,
    input  logic              io_diag_wr_valid,
    input  logic [IDX_W-1:0]  io_diag_addr,
    input  logic [1:0]        io_diag_way,
    input  logic              io_diag_tag_array,
    input  logic [DATA_W-1:0] io_diag_wr_data,
    input  logic              io_ic_busy,
    output logic [IDX_W-1:0]  io_ic_debug_addr,
    output logic              io_ic_debug_rd_en,
    output logic              io_ic_debug_wr_en,
    output logic              io_ic_debug_tag_array,
    output logic [1:0]        io_ic_debug_way,
    output logic [DATA_W-1:0] io_ic_debug_wr_data,
    input  logic [DATA_W-1:0] io_ic_debug_rd_data,
    input  logic [TAG_W-1:0]  io_ictag_debug_rd_data,
    output logic [DATA_W-1:0] io_diag_rd_data,
    output logic              io_diag_rd_data_valid,
    output logic              io_diag_wr_done,
    output logic              io_diag_busy,
    output logic              io_diag_err
);

    // The counter reaches zero on the last cycle of the wait, hence the -1.
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO_CYC - 1);

    dbg_state_t        state_reg, state_next;
    dbg_op_t           op_reg;
    logic [IDX_W-1:0]  addr_reg;
    logic [1:0]        way_reg;
    logic              tag_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              err_reg, err_next;

    logic              take_req;
    logic              any_req;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              rd_done;
    logic              tmo_fire;
    logic              in_issue;
    logic              rd_resp;
    logic [DATA_W-1:0] rd_sample;
    logic [DATA_W-1:0] rd_resp_data;

    assign any_req = io_diag_rd_valid | io_diag_wr_valid;

    el2_ifu_ic_dbg_cnt u_cnt (
        .clock    (clock),
        .io_rst_l (io_rst_l),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        take_req     = 1'b0;
        err_next     = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = RD_LOAD;
        cnt_dec      = 1'b0;
        rd_done      = 1'b0;
        tmo_fire     = 1'b0;

        case (state_reg)
            IDLE: begin
                // Simultaneous read+write: the read wins, the write is reported.
                err_next = io_diag_rd_valid & io_diag_wr_valid;
                if (any_req) begin
                    take_req = 1'b1;
                    if (io_ic_busy) begin
                        state_next   = WAIT;
                        // Preloads the grant-wait limit; inert unless the
                        // timeout build decrements it.
                        cnt_load     = 1'b1;
                        cnt_load_val = TMO_LOAD;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end

            WAIT: begin
                err_next = any_req;
                if (!io_ic_busy) begin
                    state_next = ISSUE;
`ifdef EL2_IC_DBG_TIMEOUT_EN
                end else if (cnt_zero) begin
                    state_next = IDLE;
                    tmo_fire   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
`endif
                end
            end

            ISSUE: begin
                err_next = any_req;
                if (op_reg == RD) begin
                    state_next   = RDW;
                    cnt_load     = 1'b1;
                    cnt_load_val = RD_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end

            RDW: begin
                // io_ic_busy is deliberately ignored: the array read is already in flight.
                err_next = any_req;
                if (cnt_zero) begin
                    state_next = IDLE;
                    rd_done    = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!io_rst_l) begin
            state_reg   <= IDLE;
            op_reg      <= RD;
            addr_reg    <= '0;
            way_reg     <= '0;
            tag_reg     <= 1'b0;
            wdata_reg   <= '0;
            rd_data_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (take_req) begin
                op_reg    <= io_diag_rd_valid ? RD : WR;
                addr_reg  <= io_diag_addr;
                way_reg   <= io_diag_way;
                tag_reg   <= io_diag_tag_array;
                wdata_reg <= io_diag_wr_data;
            end
            if (rd_resp) begin
                rd_data_reg <= rd_resp_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Strobes and responses are qualified with io_rst_l so an access caught
    // by reset in its final cycle never produces a response.
    assign in_issue = (state_reg == ISSUE) & io_rst_l;

    assign io_ic_debug_rd_en     = in_issue & (op_reg == RD);
    assign io_ic_debug_wr_en     = in_issue & (op_reg == WR);
    assign io_ic_debug_addr      = in_issue ? addr_reg : '0;
    assign io_ic_debug_way       = in_issue ? way_reg  : '0;
    assign io_ic_debug_tag_array = in_issue & tag_reg;
    assign io_ic_debug_wr_data   = io_ic_debug_wr_en ? wdata_reg : '0;
    assign io_diag_wr_done       = io_ic_debug_wr_en;

    assign rd_sample    = sel_rd_data(tag_reg, io_ic_debug_rd_data, io_ictag_debug_rd_data);
    // A timed-out read completes with zero data.
    assign rd_resp      = io_rst_l & (rd_done | (tmo_fire & (op_reg == RD)));
    assign rd_resp_data = rd_done ? rd_sample : '0;

    // The live word is forwarded in the completion cycle; the register
    // holds it afterwards.
    assign io_diag_rd_data       = rd_resp ? rd_resp_data : rd_data_reg;
    assign io_diag_rd_data_valid = rd_resp;
    assign io_diag_err           = io_rst_l & (err_reg | tmo_fire);
    assign io_diag_busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_el2_ifu_ic_dbg_ctl.sv
// ---------------------------------------------------------------------------
// tb_el2_ifu_ic_dbg_ctl
//   Stimulus is a per-cycle table (directed scenarios followed by random
//   traffic). A transaction-level model walks the table and queues the
//   expected strobes, completions and errors with their cycle numbers; a
//   monitor on the falling edge pops and compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_el2_ifu_ic_dbg_ctl;
    import el2_ifu_ic_dbg_pkg::*;

    localparam int RD_LAT  = 1;
    localparam int TMO_CYC = 4;
    localparam int NCYC    = 600;
`ifdef EL2_IC_DBG_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef logic [DATA_W-1:0] w_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_l;
    logic              rd_valid, wr_valid, tag_array, ic_busy;
    logic [IDX_W-1:0]  addr;
    logic [1:0]        way;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  dbg_addr;
    logic              dbg_rd_en, dbg_wr_en, dbg_tag;
    logic [1:0]        dbg_way;
    logic [DATA_W-1:0] dbg_wr_data;
    logic [DATA_W-1:0] mem_d;
    logic [TAG_W-1:0]  mem_t;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid, wr_done, diag_busy, diag_err;

    el2_ifu_ic_dbg_ctl #(.RD_LAT(RD_LAT), .TMO_CYC(TMO_CYC)) dut (
        .clock                  (clk),
        .io_rst_l               (rst_l),
        .io_diag_rd_valid       (rd_valid),
        .io_diag_wr_valid       (wr_valid),
        .io_diag_addr           (addr),
        .io_diag_way            (way),
        .io_diag_tag_array      (tag_array),
        .io_diag_wr_data        (wr_data),
        .io_ic_busy             (ic_busy),
        .io_ic_debug_addr       (dbg_addr),
        .io_ic_debug_rd_en      (dbg_rd_en),
        .io_ic_debug_wr_en      (dbg_wr_en),
        .io_ic_debug_tag_array  (dbg_tag),
        .io_ic_debug_way        (dbg_way),
        .io_ic_debug_wr_data    (dbg_wr_data),
        .io_ic_debug_rd_data    (mem_d),
        .io_ictag_debug_rd_data (mem_t),
        .io_diag_rd_data        (rd_data),
        .io_diag_rd_data_valid  (rd_data_valid),
        .io_diag_wr_done        (wr_done),
        .io_diag_busy           (diag_busy),
        .io_diag_err            (diag_err)
    );

    // Stimulus table, one entry per cycle
    bit                s_rst [NCYC];
    bit                s_rd  [NCYC];
    bit                s_wr  [NCYC];
    bit                s_busy[NCYC];
    bit                s_tag [NCYC];
    logic [IDX_W-1:0]  s_addr [NCYC];
    logic [1:0]        s_way  [NCYC];
    logic [DATA_W-1:0] s_wdata[NCYC];
    logic [DATA_W-1:0] s_mem_d[NCYC];
    logic [TAG_W-1:0]  s_mem_t[NCYC];
    bit                exp_busy[NCYC];

    typedef struct {
        int                cyc;
        logic [IDX_W-1:0]  addr;
        logic [1:0]        way;
        logic              tag;
        logic [DATA_W-1:0] data;
    } ev_t;

    ev_t q_rden[$];
    ev_t q_wren[$];
    ev_t q_valid[$];
    int  q_err[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = -1;
    bit mon_on = 1'b0;
    logic [DATA_W-1:0] hold_exp = '0;

    task automatic chk(input string name, input w_t got, input w_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    endtask

    function automatic void push_err(input int c);
        if (c < NCYC && !s_rst[c] && (q_err.size() == 0 || q_err[$] != c))
            q_err.push_back(c);
    endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        logic [95:0] tmp;
        tmp = {$urandom(), $urandom(), $urandom()};
        return tmp[DATA_W-1:0];
    endfunction

    // Transaction-level reference: one request at a time; grant on the first
    // cycle at or after the request with busy low; anything arriving while
    // occupied is reported one cycle later; reset abandons the transaction.
    task automatic build_model();
        int  t, g, stop, issue, vc, r;
        bit  tmo, rd_op;
        ev_t e;
        t = 0;
        while (t < NCYC) begin
            if (s_rst[t] || !(s_rd[t] || s_wr[t])) begin
                t++;
                continue;
            end
            rd_op = s_rd[t];
            if (s_rd[t] && s_wr[t]) push_err(t + 1);
            tmo = 1'b0;
            g   = t;
            while (g < NCYC && s_busy[g]) begin
                if (TMO_EN && (g - t) == TMO_CYC) begin
                    tmo = 1'b1;
                    break;
                end
                g++;
            end
            issue = g + 1;
            if (tmo) stop = g;
            else     stop = rd_op ? issue + RD_LAT : issue;
            r = -1;
            for (int c = t + 1; c <= stop && c < NCYC; c++) begin
                if (s_rst[c]) begin
                    r = c;
                    break;
                end
            end
            for (int c = t + 1; c <= stop && c < NCYC; c++) begin
                if (r >= 0 && c > r) break;
                exp_busy[c] = 1'b1;
                if (tmo && c == stop) push_err(c);
                if ((s_rd[c] || s_wr[c]) && c != r) push_err(c + 1);
            end
            e.addr = s_addr[t];
            e.way  = s_way[t];
            e.tag  = s_tag[t];
            e.data = rd_op ? '0 : s_wdata[t];
            if (!tmo) begin
                e.cyc = issue;
                if (issue < NCYC && (r < 0 || issue < r)) begin
                    if (rd_op) q_rden.push_back(e);
                    else       q_wren.push_back(e);
                end
                vc = issue + RD_LAT;
                if (rd_op && vc < NCYC && (r < 0 || vc < r)) begin
                    e.cyc  = vc;
                    e.data = s_tag[t] ? {{(DATA_W-TAG_W){1'b0}}, s_mem_t[vc]} : s_mem_d[vc];
                    q_valid.push_back(e);
                end
            end else if (rd_op && stop < NCYC && (r < 0 || stop < r)) begin
                e.cyc  = stop;
                e.data = '0;
                q_valid.push_back(e);
            end
            t = (r >= 0) ? r + 1 : stop + 1;
        end
    endtask

    task automatic build_table();
        int rn;
        for (int c = 0; c < NCYC; c++) begin
            s_addr[c]  = '0;
            s_way[c]   = '0;
            s_wdata[c] = '0;
            s_mem_d[c] = rand_word();
            s_mem_t[c] = TAG_W'($urandom());
        end
        // Data-array read
        s_rd[2] = 1; s_addr[2] = 9'h1A5; s_way[2] = 2'b10; s_mem_d[4] = 71'h5A_DEAD_BEEF;
        // Tag-array read
        s_rd[8] = 1; s_tag[8] = 1; s_addr[8] = 9'h0F3; s_way[8] = 2'b01; s_mem_t[10] = 26'h3FF_FFFF;
        // Write held off by busy for five cycles
        s_wr[14] = 1; s_addr[14] = 9'h055; s_way[14] = 2'b01; s_wdata[14] = 71'h7F_0123_4567_89AB_CDEF;
        for (int c = 14; c <= 18; c++) s_busy[c] = 1;
        // Read+write together, then a read during the read wait
        s_rd[24] = 1; s_wr[24] = 1; s_addr[24] = 9'h1FF; s_way[24] = 2'b10; s_wdata[24] = 71'h1;
        s_rd[26] = 1;
        // Reset during the read wait, then a fresh read
        s_rd[32] = 1; s_addr[32] = 9'h0AA; s_way[32] = 2'b01;
        s_rst[34] = 1;
        s_rd[37] = 1; s_addr[37] = 9'h101; s_way[37] = 2'b10;
        // Long busy (times out when the timeout is built)
        s_rd[42] = 1; s_addr[42] = 9'h033; s_way[42] = 2'b01;
        for (int c = 42; c <= 48; c++) s_busy[c] = 1;
        // Random traffic, quiet tail so everything drains
        for (int c = 56; c < NCYC - 20; c++) begin
            rn = $urandom_range(99);
            s_rd[c]    = (rn < 14) || (rn >= 28 && rn < 32);
            s_wr[c]    = (rn >= 14 && rn < 32);
            s_busy[c]  = ($urandom_range(99) < 30);
            s_tag[c]   = ($urandom_range(1) == 1);
            s_addr[c]  = IDX_W'($urandom());
            s_way[c]   = ($urandom_range(1) == 1) ? 2'b01 : 2'b10;
            s_wdata[c] = rand_word();
        end
    endtask

    task automatic mon_cycle(input int c);
        bit  exp_here;
        ev_t e;
        exp_here = (q_rden.size() > 0 && q_rden[0].cyc == c);
        if (dbg_rd_en || exp_here) begin
            chk("rd_en", w_t'(dbg_rd_en), w_t'(exp_here));
            if (exp_here) begin
                e = q_rden.pop_front();
                chk("rd_addr", w_t'(dbg_addr), w_t'(e.addr));
                chk("rd_way", w_t'(dbg_way), w_t'(e.way));
                chk("rd_tag_sel", w_t'(dbg_tag), w_t'(e.tag));
            end
        end
        exp_here = (q_wren.size() > 0 && q_wren[0].cyc == c);
        if (dbg_wr_en || wr_done || exp_here) begin
            chk("wr_en", w_t'(dbg_wr_en), w_t'(exp_here));
            chk("wr_done", w_t'(wr_done), w_t'(exp_here));
            if (exp_here) begin
                e = q_wren.pop_front();
                chk("wr_addr", w_t'(dbg_addr), w_t'(e.addr));
                chk("wr_way", w_t'(dbg_way), w_t'(e.way));
                chk("wr_tag_sel", w_t'(dbg_tag), w_t'(e.tag));
                chk("wr_data", dbg_wr_data, e.data);
            end
        end
        if (!dbg_rd_en && !dbg_wr_en) begin
            chk("dbg_idle_fields", w_t'({dbg_addr, dbg_way, dbg_tag}), '0);
            chk("dbg_idle_wdata", dbg_wr_data, '0);
        end
        exp_here = (q_valid.size() > 0 && q_valid[0].cyc == c);
        if (rd_data_valid || exp_here) begin
            chk("rd_valid", w_t'(rd_data_valid), w_t'(exp_here));
            if (exp_here) begin
                e = q_valid.pop_front();
                chk("rd_data", rd_data, e.data);
                hold_exp = e.data;
            end
        end else begin
            chk("rd_data_hold", rd_data, hold_exp);
        end
        if (s_rst[c]) hold_exp = '0;
        exp_here = (q_err.size() > 0 && q_err[0] == c);
        if (diag_err || exp_here) begin
            chk("err", w_t'(diag_err), w_t'(exp_here));
            if (exp_here) void'(q_err.pop_front());
        end
        chk("busy", w_t'(diag_busy), w_t'(exp_busy[c]));
        if (rd_data_valid || wr_done || diag_err)
            $display("cyc=%0d valid=%0b data=%h wr_done=%0b err=%0b busy=%0b",
                     c, rd_data_valid, rd_data, wr_done, diag_err, diag_busy);
    endtask

    always @(negedge clk) begin
        if (mon_on) mon_cycle(cyc);
    end

    initial begin
        build_table();
        build_model();
        rst_l = 0; rd_valid = 0; wr_valid = 0; addr = '0; way = '0;
        tag_array = 0; wr_data = '0; ic_busy = 0; mem_d = '0; mem_t = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_en", w_t'(dbg_rd_en), '0);
        chk("reset_wr_en", w_t'(dbg_wr_en), '0);
        chk("reset_wr_done", w_t'(wr_done), '0);
        chk("reset_valid", w_t'(rd_data_valid), '0);
        chk("reset_err", w_t'(diag_err), '0);
        chk("reset_busy", w_t'(diag_busy), '0);
        chk("reset_rd_data", rd_data, '0);
        chk("reset_dbg_fields", w_t'({dbg_addr, dbg_way, dbg_tag}), '0);
        chk("reset_dbg_wdata", dbg_wr_data, '0);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            rst_l     = !s_rst[c];
            rd_valid  = s_rd[c];
            wr_valid  = s_wr[c];
            ic_busy   = s_busy[c];
            tag_array = s_tag[c];
            addr      = s_addr[c];
            way       = s_way[c];
            wr_data   = s_wdata[c];
            mem_d     = s_mem_d[c];
            mem_t     = s_mem_t[c];
            cyc       = c;
            mon_on    = 1'b1;
        end
        @(posedge clk);
        #1;
        mon_on = 1'b0;
        rd_valid = 0; wr_valid = 0; ic_busy = 0;
        repeat (2) @(negedge clk);
        chk("left_rd_en", w_t'(q_rden.size()), '0);
        chk("left_wr_en", w_t'(q_wren.size()), '0);
        chk("left_valid", w_t'(q_valid.size()), '0);
        chk("left_err", w_t'(q_err.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
